// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: EX -> MEM pipeline boundary built as a 2-entry skid buffer.
//
// Holds the EX result, destination register address and write enable. Both sides use
// valid/ready handshakes. in_ready_o is derived from registered state only, so a MEM-side
// stall never reaches EX combinationally. A combinational forwarding lookup lets EX bypass
// results that are still held here.
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   rst            synchronous active-low reset
//   flush_i        discard all held entries (overrides push/pop)
//   in_valid_i     EX presents an entry
//   in_ready_o     boundary can accept an entry this cycle
//   result_i       EX result
//   writeAddr_i    destination register
//   writeEnable_i  register write request
//   out_valid_o    oldest entry valid
//   out_ready_i    MEM consumes the oldest entry this cycle
//   result_o       oldest entry result
//   writeAddr_o    oldest entry destination
//   writeEnable_o  oldest entry write enable, gated by out_valid_o
//   fwdQueryAddr_i register address EX wants bypassed
//   fwdHit_o       a held entry will write fwdQueryAddr_i
//   fwdData_o      result of the youngest matching entry, else 0
//   count_o        occupancy, 0..2
module ex_mem_pipe #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] result_i,
    input  logic [ADDR_WIDTH-1:0] writeAddr_i,
    input  logic                  writeEnable_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic [ADDR_WIDTH-1:0] writeAddr_o,
    output logic                  writeEnable_o,
    input  logic [ADDR_WIDTH-1:0] fwdQueryAddr_i,
    output logic                  fwdHit_o,
    output logic [DATA_WIDTH-1:0] fwdData_o,
    output logic [1:0]            count_o
);

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StFull
    } state_e;

    state_e                state_q;
    logic [DATA_WIDTH-1:0] main_result_q, skid_result_q;
    logic [ADDR_WIDTH-1:0] main_addr_q, skid_addr_q;
    logic                  main_we_q, skid_we_q;

    logic main_valid, skid_valid;
    logic push, pop;
    logic main_match, skid_match;

    // Slot valid bits follow directly from the occupancy state.
    always_comb begin
        main_valid = (state_q == StOne) || (state_q == StFull);
        skid_valid = (state_q == StFull);
    end

    always_comb begin
        in_ready_o    = rst & (state_q != StFull);
        out_valid_o   = main_valid;
        result_o      = main_result_q;
        writeAddr_o   = main_addr_q;
        writeEnable_o = main_we_q & main_valid;
        push          = in_valid_i & in_ready_o;
        pop           = out_valid_o & out_ready_i;
    end

    always_comb begin
        count_o = 2'd0;
        case (state_q)
            StOne:   count_o = 2'd1;
            StFull:  count_o = 2'd2;
            default: count_o = 2'd0;
        endcase
    end

    // Forwarding: skid holds the younger entry, so it wins over main. Address 0 never hits.
    always_comb begin
        skid_match = skid_valid & skid_we_q & (skid_addr_q == fwdQueryAddr_i) &
                     (fwdQueryAddr_i != '0);
        main_match = main_valid & main_we_q & (main_addr_q == fwdQueryAddr_i) &
                     (fwdQueryAddr_i != '0);
        fwdHit_o   = skid_match | main_match;
        fwdData_o  = '0;
        if (skid_match) begin
            fwdData_o = skid_result_q;
        end else if (main_match) begin
            fwdData_o = main_result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || flush_i) begin
            state_q       <= StEmpty;
            main_result_q <= '0;
            main_addr_q   <= '0;
            main_we_q     <= 1'b0;
            skid_result_q <= '0;
            skid_addr_q   <= '0;
            skid_we_q     <= 1'b0;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (push) begin
                        state_q       <= StOne;
                        main_result_q <= result_i;
                        main_addr_q   <= writeAddr_i;
                        main_we_q     <= writeEnable_i;
                    end
                end
                StOne: begin
                    if (push && pop) begin
                        main_result_q <= result_i;
                        main_addr_q   <= writeAddr_i;
                        main_we_q     <= writeEnable_i;
                    end else if (push) begin
                        // MEM stalled: park the new entry so main stays stable.
                        state_q       <= StFull;
                        skid_result_q <= result_i;
                        skid_addr_q   <= writeAddr_i;
                        skid_we_q     <= writeEnable_i;
                    end else if (pop) begin
                        state_q       <= StEmpty;
                        main_result_q <= '0;
                        main_addr_q   <= '0;
                        main_we_q     <= 1'b0;
                    end
                end
                StFull: begin
                    if (pop) begin
                        state_q       <= StOne;
                        main_result_q <= skid_result_q;
                        main_addr_q   <= skid_addr_q;
                        main_we_q     <= skid_we_q;
                        skid_result_q <= '0;
                        skid_addr_q   <= '0;
                        skid_we_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StEmpty;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_mem_pipe.sv
module tb_ex_mem_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] result_i = '0;
    logic [4:0]  writeAddr_i = '0;
    logic        writeEnable_i = 1'b0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] result_o;
    logic [4:0]  writeAddr_o;
    logic        writeEnable_o;
    logic [4:0]  fwdQueryAddr_i = '0;
    logic        fwdHit_o;
    logic [31:0] fwdData_o;
    logic [1:0]  count_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ex_mem_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .result_i      (result_i),
        .writeAddr_i   (writeAddr_i),
        .writeEnable_i (writeEnable_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .result_o      (result_o),
        .writeAddr_o   (writeAddr_o),
        .writeEnable_o (writeEnable_o),
        .fwdQueryAddr_i(fwdQueryAddr_i),
        .fwdHit_o      (fwdHit_o),
        .fwdData_o     (fwdData_o),
        .count_o       (count_o)
    );

    // Reference model: a FIFO of at most two entries, oldest at index 0.
    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  addr;
        logic        we;
    } ent_t;

    ent_t q[$];

    // Expected {out_valid, in_ready, count, result, addr, we, fwdHit, fwdData}.
    function automatic logic [74:0] exp_vec();
        ent_t        f = '0;
        logic        fh = 1'b0;
        logic [31:0] fd = '0;
        if (q.size() > 0) f = q[0];
        // Later (younger) matches overwrite older ones.
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].we && q[i].addr == fwdQueryAddr_i && fwdQueryAddr_i != 5'd0) begin
                fh = 1'b1;
                fd = q[i].result;
            end
        end
        return {q.size() > 0, rst && q.size() < 2, 2'(q.size()), f.result, f.addr, f.we,
                fh, fd};
    endfunction

    function automatic logic [74:0] dut_vec();
        return {out_valid_o, in_ready_o, count_o, result_o, writeAddr_o, writeEnable_o,
                fwdHit_o, fwdData_o};
    endfunction

    // Advance one clock edge, updating the model with the handshake seen at that edge.
    task automatic tick();
        bit push, pop;
        push = in_valid_i && rst && q.size() < 2;
        pop  = out_ready_i && q.size() > 0;
        @(posedge clk);
        if (!rst || flush_i) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back('{result: result_i, addr: writeAddr_i, we: writeEnable_i});
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] r, input logic [4:0] a,
                         input logic we);
        in_valid_i    = v;
        result_i      = r;
        writeAddr_i   = a;
        writeEnable_i = we;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        out_ready_i = 1'b0;
        drive(1'b1, 32'h5, 5'd3, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({out_valid_o, in_ready_o, count_o} !== 4'b0000) begin
                failures++;
                $display("FAIL reset_hold: valid/ready/count=%b required 0000",
                         {out_valid_o, in_ready_o, count_o});
            end
        end
        checks++;
        if ({result_o, writeAddr_o, writeEnable_o, fwdHit_o, fwdData_o} !== '0) begin
            failures++;
            $display("FAIL reset_fields: result=%h addr=%h we=%b hit=%b fwd=%h required 0",
                     result_o, writeAddr_o, writeEnable_o, fwdHit_o, fwdData_o);
        end
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: got %b required 1", in_ready_o);
        end
    endtask

    task automatic test_streaming();
        logic [31:0] vals [3];
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
        out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, vals[i], 5'(i + 1), 1'b1);
            tick();
            if (i == 2) drive(1'b0, 32'h0, 5'd0, 1'b0);
            #1;
            checks++;
            if ({out_valid_o, in_ready_o, count_o, result_o, writeAddr_o} !==
                {1'b1, 1'b1, 2'd1, vals[i], 5'(i + 1)}) begin
                failures++;
                $display("FAIL stream_%0d: v=%b rdy=%b cnt=%0d res=%h addr=%0d required 1 1 1 %h %0d",
                         i, out_valid_o, in_ready_o, count_o, result_o, writeAddr_o, vals[i], i + 1);
            end
        end
        tick();
        checks++;
        if (out_valid_o !== 1'b0 || count_o !== 2'd0) begin
            failures++;
            $display("FAIL stream_drain: valid=%b count=%0d required 0 0", out_valid_o, count_o);
        end
    endtask

    task automatic test_backpressure();
        out_ready_i = 1'b0;
        drive(1'b1, 32'hAA, 5'd4, 1'b1);
        tick();
        drive(1'b1, 32'hBB, 5'd5, 1'b1);
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if ({count_o, in_ready_o, result_o, writeAddr_o} !== {2'd2, 1'b0, 32'hAA, 5'd4}) begin
                failures++;
                $display("FAIL bp_stall_%0d: cnt=%0d rdy=%b res=%h addr=%0d required 2 0 aa 4",
                         i, count_o, in_ready_o, result_o, writeAddr_o);
            end
            tick();
        end
        out_ready_i = 1'b1;
        tick();
        checks++;
        if ({count_o, in_ready_o, result_o, writeAddr_o} !== {2'd1, 1'b1, 32'hBB, 5'd5}) begin
            failures++;
            $display("FAIL bp_pop1: cnt=%0d rdy=%b res=%h addr=%0d required 1 1 bb 5",
                     count_o, in_ready_o, result_o, writeAddr_o);
        end
        tick();
        checks++;
        if (out_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL bp_pop2: valid=%b required 0", out_valid_o);
        end
    endtask

    task automatic test_forwarding();
        out_ready_i = 1'b0;
        drive(1'b1, 32'h100, 5'd7, 1'b1);
        tick();
        drive(1'b1, 32'h200, 5'd7, 1'b1);
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        fwdQueryAddr_i = 5'd7;
        #1;
        checks++;
        if ({fwdHit_o, fwdData_o} !== {1'b1, 32'h200}) begin
            failures++;
            $display("FAIL fwd_skid_priority: hit=%b data=%h required 1 200", fwdHit_o, fwdData_o);
        end
        fwdQueryAddr_i = 5'd0;
        #1;
        checks++;
        if ({fwdHit_o, fwdData_o} !== 33'd0) begin
            failures++;
            $display("FAIL fwd_addr0: hit=%b data=%h required 0 0", fwdHit_o, fwdData_o);
        end
        fwdQueryAddr_i = 5'd9;
        #1;
        checks++;
        if ({fwdHit_o, fwdData_o} !== 33'd0) begin
            failures++;
            $display("FAIL fwd_miss: hit=%b data=%h required 0 0", fwdHit_o, fwdData_o);
        end
        // Refill with the younger entry write-disabled.
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        drive(1'b1, 32'h100, 5'd7, 1'b1);
        tick();
        drive(1'b1, 32'h200, 5'd7, 1'b0);
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        fwdQueryAddr_i = 5'd7;
        #1;
        checks++;
        if ({fwdHit_o, fwdData_o, count_o} !== {1'b1, 32'h100, 2'd2}) begin
            failures++;
            $display("FAIL fwd_skid_we0: hit=%b data=%h cnt=%0d required 1 100 2",
                     fwdHit_o, fwdData_o, count_o);
        end
    endtask

    task automatic test_flush();
        // Boundary is FULL here; flush with a simultaneous push and pop.
        flush_i = 1'b1;
        out_ready_i = 1'b1;
        drive(1'b1, 32'hDEAD, 5'd3, 1'b1);
        tick();
        flush_i = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if ({count_o, out_valid_o, writeEnable_o, result_o} !== 36'd0) begin
                failures++;
                $display("FAIL flush_%0d: cnt=%0d valid=%b we=%b res=%h required 0 0 0 0",
                         i, count_o, out_valid_o, writeEnable_o, result_o);
            end
            tick();
        end
    endtask

    task automatic test_bubble();
        out_ready_i = 1'b0;
        drive(1'b1, 32'h66, 5'd6, 1'b0);
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        fwdQueryAddr_i = 5'd6;
        #1;
        checks++;
        if ({out_valid_o, writeEnable_o, count_o, fwdHit_o, writeAddr_o} !==
            {1'b1, 1'b0, 2'd1, 1'b0, 5'd6}) begin
            failures++;
            $display("FAIL bubble: v=%b we=%b cnt=%0d hit=%b addr=%0d required 1 0 1 0 6",
                     out_valid_o, writeEnable_o, count_o, fwdHit_o, writeAddr_o);
        end
        out_ready_i = 1'b1;
        tick();
    endtask

    task automatic test_reset_in_full();
        out_ready_i = 1'b0;
        drive(1'b1, 32'h1, 5'd1, 1'b1);
        tick();
        tick();
        rst = 1'b0;
        out_ready_i = 1'b1;
        tick();
        #1;
        checks++;
        if ({count_o, in_ready_o, out_valid_o, result_o} !== 36'd0) begin
            failures++;
            $display("FAIL reset_full: cnt=%0d rdy=%b v=%b res=%h required 0 0 0 0",
                     count_o, in_ready_o, out_valid_o, result_o);
        end
        rst = 1'b1;
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        tick();
    endtask

    task automatic test_random();
        logic [74:0] got, want;
        for (int i = 0; i < 600; i++) begin
            rst            = ($urandom_range(40, 0) != 0);
            flush_i        = ($urandom_range(15, 0) == 0);
            out_ready_i    = ($urandom_range(2, 0) != 0);
            in_valid_i     = ($urandom_range(3, 0) != 0);
            result_i       = $urandom();
            writeAddr_i    = 5'($urandom_range(7, 0));
            writeEnable_i  = ($urandom_range(3, 0) != 0);
            fwdQueryAddr_i = 5'($urandom_range(7, 0));
            #1;
            got  = dut_vec();
            want = exp_vec();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL random_%0d: {v,rdy,cnt,res,addr,we,hit,fwd} got %h required %h",
                         i, got, want);
            end
            tick();
        end
        rst = 1'b1;
        flush_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_forwarding();
        test_flush();
        test_bubble();
        test_reset_in_full();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
